// File: rtl/viterbi_pkg.sv
// Shared encoder/decoder definitions: code parameters, FSM state and symbol types.
package viterbi_pkg;

    localparam int             K  = 3;
    localparam logic [K-1:0]   G0 = 3'b111;
    localparam logic [K-1:0]   G1 = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2
    } enc_state_t;

    typedef logic [1:0] symbol_t;

    // w[K-1] is the newest bit; each generator bit taps the matching window position.
    function automatic symbol_t encode_sym(input logic [K-1:0] w);
        return {^(w & G0), ^(w & G1)};
    endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Convolutional encoder datapath: K-1 bit shift register and registered parity symbol.
module conv_enc_core
    import viterbi_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    step,
    input  logic    b,
    output symbol_t sym,
    output logic    sr_zero
);

    logic [K-2:0] sr_q, sr_d;
    symbol_t      sym_q, sym_d;
    logic [K-1:0] w;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w     = {b, sr_q};
        sr_d  = sr_q;
        sym_d = sym_q;
        if (step) begin
            sr_d  = w[K-1:1];
            sym_d = encode_sym(w);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            sym_q <= '0;
        end else begin
            sr_q  <= sr_d;
            sym_q <= sym_d;
        end
    end

    assign sym     = sym_q;
    assign sr_zero = (sr_q == '0);

endmodule

// File: rtl/conv_frame_encoder.sv
// Rate-1/2 framed convolutional encoder: FRAME_LEN info symbols, then K-1 zero-tail symbols.
module conv_frame_encoder
    import viterbi_pkg::*;
#(
    parameter int          FRAME_LEN    = 64,
    // Frame counter reset value; nonzero only to reach the 16-bit wrap quickly.
    parameter logic [15:0] FRAME_CT_RST = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_i,
    input  logic        d_in,
    output logic        ready_o,
    output logic        valid_o,
    output logic [1:0]  d_out,
    output logic        sop_o,
    output logic        eop_o,
    output logic        drop_o,
    output logic [15:0] frame_ct_o
);

    localparam int BCW = $clog2(FRAME_LEN + 1);
    localparam int TCW = $clog2(K);
    localparam logic [BCW-1:0] LAST_BIT_M1 = BCW'(FRAME_LEN - 1);
    localparam logic [TCW-1:0] LAST_TAIL   = TCW'(K - 2);

    enc_state_t     state_q, state_d;
    logic [BCW-1:0] bit_ct_q, bit_ct_d;
    logic [TCW-1:0] tail_ct_q, tail_ct_d;
    logic [15:0]    frame_ct_q, frame_ct_d;
    logic           valid_q, sop_q, sop_d, eop_q, eop_d, drop_q, drop_d;

    logic    in_tail, accept, step, enc_b, sr_zero;
    symbol_t sym;

    assign in_tail = (state_q == TAIL);
    assign ready_o = ~in_tail;
    assign accept  = enable_i & ready_o;
    assign step    = accept | in_tail;
    assign enc_b   = d_in & ~in_tail;

    conv_enc_core u_core (
        .clk     (clk),
        .rst     (rst),
        .step    (step),
        .b       (enc_b),
        .sym     (sym),
        .sr_zero (sr_zero)
    );

    always_comb begin
        state_d    = state_q;
        bit_ct_d   = bit_ct_q;
        tail_ct_d  = tail_ct_q;
        frame_ct_d = frame_ct_q;
        sop_d      = 1'b0;
        eop_d      = 1'b0;
        drop_d     = enable_i & ~ready_o;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    bit_ct_d = BCW'(1);
                    sop_d    = 1'b1;
                    state_d  = (FRAME_LEN == 1) ? TAIL : DATA;
                end
            end
            DATA: begin
                if (accept) begin
                    bit_ct_d = bit_ct_q + BCW'(1);
                    if (bit_ct_q == LAST_BIT_M1) state_d = TAIL;
                end
            end
            TAIL: begin
                if (tail_ct_q == LAST_TAIL) begin
                    tail_ct_d  = '0;
                    bit_ct_d   = '0;
                    eop_d      = 1'b1;
                    frame_ct_d = frame_ct_q + 16'd1;
                    state_d    = IDLE;
                end else begin
                    tail_ct_d = tail_ct_q + TCW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_ct_q   <= '0;
            tail_ct_q  <= '0;
            frame_ct_q <= FRAME_CT_RST;
            valid_q    <= 1'b0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_ct_q   <= bit_ct_d;
            tail_ct_q  <= tail_ct_d;
            frame_ct_q <= frame_ct_d;
            valid_q    <= step;
            sop_q      <= sop_d;
            eop_q      <= eop_d;
            drop_q     <= drop_d;
        end
    end

    // Zero-tail termination guarantees every frame begins from the all-zero state.
    idle_sr_zero_a: assert property (@(posedge clk) disable iff (rst)
        (state_q == IDLE) |-> sr_zero);

    assign valid_o    = valid_q;
    assign d_out      = sym;
    assign sop_o      = sop_q;
    assign eop_o      = eop_q;
    assign drop_o     = drop_q;
    assign frame_ct_o = frame_ct_q;

endmodule

// File: tb/tb_conv_frame_encoder.sv
// Self-checking bench: golden tables plus a sequence-level reference model with random stimulus.
module tb_conv_frame_encoder;
    import viterbi_pkg::*;

    localparam int FL4 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        en1, d1, ready1, valid1, sop1, eop1, drop1;
    logic [1:0]  dout1;
    logic [15:0] ct1;
    logic        en2, d2, ready2, valid2, sop2, eop2, drop2;
    logic [1:0]  dout2;
    logic [15:0] ct2;

    conv_frame_encoder #(.FRAME_LEN(FL4)) dut_fl4 (
        .clk(clk), .rst(rst), .enable_i(en1), .d_in(d1), .ready_o(ready1),
        .valid_o(valid1), .d_out(dout1), .sop_o(sop1), .eop_o(eop1),
        .drop_o(drop1), .frame_ct_o(ct1)
    );

    conv_frame_encoder #(.FRAME_LEN(1), .FRAME_CT_RST(16'hFFFE)) dut_fl1 (
        .clk(clk), .rst(rst), .enable_i(en2), .d_in(d2), .ready_o(ready2),
        .valid_o(valid2), .d_out(dout2), .sop_o(sop2), .eop_o(eop2),
        .drop_o(drop2), .frame_ct_o(ct2)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        en;
        logic        d;
        logic        rdy;
        logic        v;
        logic [1:0]  dout;
        logic        sop;
        logic        eop;
        logic        drop;
        logic [15:0] ct;
    } vec_t;

    task automatic apply_row(input int which, input int idx, input vec_t r);
        logic v, so, eo, dr;
        logic [1:0] dq;
        logic [15:0] ct;
        if (which == 0) begin
            en1 = r.en; d1 = r.d;
            check($sformatf("t%0d[%0d].ready", which, idx), ready1, r.rdy);
        end else begin
            en2 = r.en; d2 = r.d;
            check($sformatf("t%0d[%0d].ready", which, idx), ready2, r.rdy);
        end
        @(posedge clk); #1;
        if (which == 0) begin v = valid1; dq = dout1; so = sop1; eo = eop1; dr = drop1; ct = ct1; end
        else            begin v = valid2; dq = dout2; so = sop2; eo = eop2; dr = drop2; ct = ct2; end
        check($sformatf("t%0d[%0d].valid", which, idx), v, r.v);
        check($sformatf("t%0d[%0d].d_out", which, idx), dq, r.dout);
        check($sformatf("t%0d[%0d].sop", which, idx), so, r.sop);
        check($sformatf("t%0d[%0d].eop", which, idx), eo, r.eop);
        check($sformatf("t%0d[%0d].drop", which, idx), dr, r.drop);
        check($sformatf("t%0d[%0d].frame_ct", which, idx), ct, r.ct);
    endtask

    // Reference model: symbols computed directly from the zero-padded frame bit sequence.
    bit          m_bits[$];
    int          m_tail_left;
    logic [15:0] m_frames;
    logic [1:0]  m_dout;
    int          sym_seen, drop_seen, idle_seen;

    function automatic bit model_bit(input int i);
        if (i < 0 || i >= m_bits.size()) return 1'b0;
        return m_bits[i];
    endfunction

    function automatic logic [1:0] model_sym(input int n);
        logic p0, p1;
        p0 = 1'b0; p1 = 1'b0;
        for (int j = 0; j < K; j++) begin
            p0 ^= model_bit(n - j) & G0[K-1-j];
            p1 ^= model_bit(n - j) & G1[K-1-j];
        end
        return {p0, p1};
    endfunction

    task automatic step_model(input logic en, input logic d);
        logic e_ready, e_valid, e_sop, e_eop, e_drop;
        e_ready = (m_tail_left == 0);
        check("m.ready", ready1, e_ready);
        e_valid = 1'b0; e_sop = 1'b0; e_eop = 1'b0;
        e_drop  = en & ~e_ready;
        if (!e_ready) begin
            m_dout  = model_sym(m_bits.size() + (K - 1 - m_tail_left));
            e_valid = 1'b1;
            m_tail_left--;
            if (m_tail_left == 0) begin
                e_eop = 1'b1;
                m_frames++;
                m_bits.delete();
            end
        end else if (en) begin
            m_bits.push_back(d);
            m_dout  = model_sym(m_bits.size() - 1);
            e_valid = 1'b1;
            e_sop   = (m_bits.size() == 1);
            if (m_bits.size() == FL4) m_tail_left = K - 1;
        end
        en1 = en; d1 = d;
        @(posedge clk); #1;
        check("m.valid", valid1, e_valid);
        check("m.d_out", dout1, m_dout);
        check("m.sop", sop1, e_sop);
        check("m.eop", eop1, e_eop);
        check("m.drop", drop1, e_drop);
        check("m.frame_ct", ct1, m_frames);
        if (valid1) sym_seen++; else idle_seen++;
        if (drop1) drop_seen++;
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_tail_left = 0;
        m_frames    = 16'd0;
        m_dout      = 2'b00;
    endtask

    vec_t gold[7];
    vec_t wrap[7];
    logic [15:0] ct_base;

    initial begin
        gold[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 16'd0};
        gold[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 16'd0};
        gold[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 16'd0};
        gold[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 16'd0};
        gold[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 16'd0};
        gold[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 16'd1};
        gold[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 16'd1};

        wrap[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 16'hFFFE};
        wrap[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 16'hFFFE};
        wrap[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 16'hFFFF};
        wrap[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 16'hFFFF};
        wrap[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 16'hFFFF};
        wrap[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0000};
        wrap[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000};

        rst = 1'b1; en1 = 1'b0; d1 = 1'b0; en2 = 1'b0; d2 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("init.ready", ready1, 1'b1);
        check("init.valid", valid1, 1'b0);
        check("init.d_out", dout1, 2'b00);
        check("init.frame_ct", ct1, 16'd0);
        check("init.fl1_ct", ct2, 16'hFFFE);

        // Golden frame 1,0,1,1 -> 11,10,00,01 then tail 01,11.
        for (int i = 0; i < 7; i++) apply_row(0, i, gold[i]);

        // Single-bit frames with the counter wrapping through FFFF to 0.
        for (int i = 0; i < 7; i++) apply_row(1, i, wrap[i]);

        model_reset();
        m_frames = 16'd1;
        m_dout   = 2'b11;

        // Stall: two idle cycles between bits 2 and 3.
        sym_seen = 0; drop_seen = 0; idle_seen = 0;
        step_model(1'b1, 1'b1);
        step_model(1'b1, 1'b0);
        step_model(1'b0, 1'b0);
        step_model(1'b0, 1'b1);
        step_model(1'b1, 1'b1);
        step_model(1'b1, 1'b1);
        step_model(1'b0, 1'b0);
        step_model(1'b0, 1'b0);
        check("stall.symbols", sym_seen, 6);
        check("stall.idle", idle_seen, 2);
        check("stall.drops", drop_seen, 0);

        // Overrun: enable held high through the tail; next frame starts clean.
        sym_seen = 0; drop_seen = 0;
        step_model(1'b1, 1'b1);
        step_model(1'b1, 1'b0);
        step_model(1'b1, 1'b1);
        step_model(1'b1, 1'b1);
        step_model(1'b1, 1'b0);
        step_model(1'b1, 1'b1);
        check("overrun.drops", drop_seen, 2);
        step_model(1'b1, 1'b1);
        check("overrun.next_sop", sop1, 1'b1);
        check("overrun.next_sym", dout1, 2'b11);
        for (int i = 0; i < 5; i++) step_model(1'b0, 1'b0);

        // Back-to-back: three frames of random bits with continuous enable.
        sym_seen = 0;
        ct_base  = ct1;
        for (int i = 0; i < 3 * (FL4 + K - 1); i++) step_model(1'b1, 1'($urandom));
        check("b2b.symbols", sym_seen, 3 * (FL4 + K - 1));
        check("b2b.frames", ct1 - ct_base, 16'd3);
        check("b2b.ready_after", ready1, 1'b1);

        // Random enable and data against the model.
        for (int i = 0; i < 400; i++) step_model(1'($urandom_range(0, 3) != 0), 1'($urandom));
        while (m_tail_left != 0 || m_bits.size() == 0) step_model(1'b1, 1'($urandom));
        step_model(1'b1, 1'b1);

        // Reset mid-frame, held three cycles with enable active.
        rst = 1'b1; en1 = 1'b1; d1 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; en1 = 1'b0;
        check("rst.ready", ready1, 1'b1);
        check("rst.valid", valid1, 1'b0);
        check("rst.d_out", dout1, 2'b00);
        check("rst.sop", sop1, 1'b0);
        check("rst.eop", eop1, 1'b0);
        check("rst.drop", drop1, 1'b0);
        check("rst.frame_ct", ct1, 16'd0);
        model_reset();
        step_model(1'b0, 1'b0);
        for (int i = 0; i < 12; i++) step_model(1'b1, 1'($urandom));
        for (int i = 0; i < 3; i++) step_model(1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
